// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers, fill level, status and sticky error flags.
// Define RING_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module ring_fifo #(
  parameter int pBITS  = 8,
  parameter int pWIDHT = 2,
  parameter int pAFULL = 3
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iwr_en,
  input  logic [pBITS-1:0]  iw_data,
  input  logic              ird_en,
  input  logic              iclr_err,
  output logic [pBITS-1:0]  or_data,
  output logic              or_valid,
  output logic              ofull,
  output logic              oempty,
  output logic              oalmost_full,
  output logic [pWIDHT:0]   olevel,
  output logic              ooverflow,
  output logic              ounderflow
);

  localparam int DEPTH = 1 << pWIDHT;
  localparam logic [pWIDHT:0] AFULL_LV = pAFULL[pWIDHT:0];

  logic [pBITS-1:0]  rarray [DEPTH];
  logic [pWIDHT:0]   wptr;
  logic [pWIDHT:0]   rptr;
  logic [pWIDHT-1:0] waddr;
  logic [pWIDHT-1:0] raddr;
  logic              empty;
  logic              full;
  logic              wr_acc;
  logic              rd_acc;

  assign waddr = wptr[pWIDHT-1:0];
  assign raddr = rptr[pWIDHT-1:0];

  // The MSB is the wrap bit: equal low bits with differing wrap bits means a full lap ahead.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[pWIDHT] != rptr[pWIDHT]) && (waddr == raddr);
  assign wr_acc = iwr_en && !full;
  assign rd_acc = ird_en && !empty;

  assign oempty       = empty;
  assign ofull        = full;
  assign olevel       = wptr - rptr;
  assign oalmost_full = (olevel >= AFULL_LV);

  always_ff @(posedge iclk) begin
    if (irst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge iclk) begin
    if (!irst && wr_acc) rarray[waddr] <= iw_data;
  end

  // A new error in the same cycle as a clear takes priority.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ooverflow  <= 1'b0;
      ounderflow <= 1'b0;
    end else begin
      if (iwr_en && full)
        ooverflow <= 1'b1;
      else if (iclr_err)
        ooverflow <= 1'b0;
      if (ird_en && empty)
        ounderflow <= 1'b1;
      else if (iclr_err)
        ounderflow <= 1'b0;
    end
  end

`ifdef RING_FIFO_FWFT_EN
  assign or_data  = rarray[raddr];
  assign or_valid = !empty;
`else
  logic [pBITS-1:0] data_p1;
  logic             vld_p1;

  // p0 -> p1: head word captured on an accepted read, valid for one cycle
  always_ff @(posedge iclk) begin
    if (irst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) data_p1 <= rarray[raddr];
    end
  end

  assign or_data  = data_p1;
  assign or_valid = vld_p1;
`endif

endmodule
